ysyx_24080014_ifu: RTL and testbench
====================================

# ysyx_24080014_ifu

Multi-cycle instruction fetch unit that replaces the combinational fetch path in front of the decoder. It owns the PC, issues one request per instruction to the instruction memory over a valid/ready request channel, captures the response, and presents the instruction to the decode stage over a valid/ready handshake. It then waits for the execute/write-back side to return the next PC.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address
- imem_rsp_valid  in  1  response valid (single-cycle pulse, no ready)
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of `inst`
- inst_err  out  1  fetch fault (access or misalign) for `inst`
- wb_valid  in  1  previous instruction committed, next PC valid
- wb_next_pc  in  32  PC of next instruction

## Operation
- States: IDLE, FETCH, WAIT_RSP, DELIVER, WAIT_WB.
- IDLE: entered on reset; unconditionally -> FETCH next cycle.
- FETCH: imem_req_valid=1, imem_req_addr=pc; on valid&ready -> WAIT_RSP. Address held stable while ready is low.
- WAIT_RSP: on imem_rsp_valid register inst<=imem_rsp_data, inst_err<=imem_rsp_err, inst_pc<=pc -> DELIVER.
- DELIVER: inst_valid=1, inst/inst_pc/inst_err stable until inst_ready; on inst_valid&inst_ready -> WAIT_WB.
- WAIT_WB: on wb_valid pc<=wb_next_pc -> FETCH.
- imem_rsp_valid outside WAIT_RSP ignored; wb_valid outside WAIT_WB ignored.
- Response in the same cycle as request acceptance is ignored; memory returns data no earlier than the cycle after acceptance.
- An erroring response is still delivered (inst_err=1, inst=captured data); decode decides the trap.
- pc is 32-bit, wraps 32'hFFFF_FFFC -> whatever wb_next_pc gives; no internal increment.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, inst_err=0.
- Reset mid-operation (any state) returns to IDLE next cycle; memory shares rst and drops outstanding responses.
- Reset deasserted at cycle 0: request visible cycle 1.
- Best case request accepted cycle N, response N+1, inst_valid N+2, WAIT_WB N+3 if inst_ready high, next request one cycle after wb_valid.
- All outputs registered or decoded from registered state only; no combinational path from any input to any output.

## Configuration
- YSYX_24080014_IFU_MISALIGN_CHK_EN defined: in FETCH with pc[1:0]!=0 no request is issued; next cycle DELIVER with inst=32'h0000_0013, inst_err=1, inst_pc=pc.
- Not defined: imem_req_addr = {pc[31:2],2'b00}; misaligned PCs fetch silently; inst_err only from imem_rsp_err.

## Structure
- Package ysyx_24080014_ifu_pkg: state enum, RESET_PC default, NOP constant 32'h0000_0013.
- Single module; no sub-module warranted.

## Test plan
- Reset release, imem_req_ready=1, rsp 32'h0000_0093 next cycle -> imem_req_addr=32'h8000_0000 at cycle 1, inst_valid at cycle 3 with inst=32'h0000_0093, inst_pc=32'h8000_0000.
- imem_req_ready low 4 cycles -> imem_req_valid held 1, addr stable, single WAIT_RSP entry on 5th cycle.
- inst_ready low 3 cycles in DELIVER -> inst/inst_pc/inst_err unchanged; wb_valid pulsed during DELIVER ignored, pc unchanged.
- wb_valid with wb_next_pc=32'h8000_0100 -> next imem_req_addr=32'h8000_0100.
- imem_rsp_err=1 -> inst_err=1 with captured data; stray rsp_valid in WAIT_WB ignored.
- With macro: wb_next_pc=32'h8000_0102 -> no imem_req_valid, inst_valid next-next cycle, inst=32'h0000_0013, inst_err=1; without macro: imem_req_addr=32'h8000_0100. Reset asserted in WAIT_RSP -> IDLE, outputs at reset values.

Source files
------------

// File: rtl/ysyx_24080014_ifu_pkg.sv
// Shared definitions for the multi-cycle instruction fetch unit.
//   - FSM state encodings (3-bit localparams) and the state type
//   - RESET_PC_DEFAULT : PC loaded on reset
//   - NOP_INST         : addi x0,x0,0, shown on inst while nothing was fetched
package ysyx_24080014_ifu_pkg;

    typedef logic [2:0] ifu_state_t;

    localparam ifu_state_t IFU_IDLE     = 3'd0;
    localparam ifu_state_t IFU_FETCH    = 3'd1;
    localparam ifu_state_t IFU_WAIT_RSP = 3'd2;
    localparam ifu_state_t IFU_DELIVER  = 3'd3;
    localparam ifu_state_t IFU_WAIT_WB  = 3'd4;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24080014_ifu.sv
// Multi-cycle instruction fetch unit. Owns the PC, issues one memory request
// per instruction, captures the response and hands it to decode, then waits
// for the back end to supply the next PC.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel (word address)
//   imem_rsp_valid/data/err          single-cycle response pulse, no ready
//   inst_valid/ready, inst,
//   inst_pc, inst_err                instruction handed to decode
//   wb_valid, wb_next_pc             next PC from execute/write-back
//
// Optional build macro: YSYX_24080014_IFU_MISALIGN_CHK_EN
//   defined   : a PC with pc[1:0]!=0 issues no request and delivers a NOP
//               flagged with inst_err=1
//   undefined : misaligned PCs fetch the enclosing word silently
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | just out of reset, moves to FETCH next cycle
// FETCH    | request presented, waiting for imem_req_ready
// WAIT_RSP | request accepted, waiting for imem_rsp_valid
// DELIVER  | instruction presented, waiting for inst_ready
// WAIT_WB  | waiting for wb_valid to supply the next PC
module ysyx_24080014_ifu
    import ysyx_24080014_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,

    input  logic        wb_valid,
    input  logic [31:0] wb_next_pc
);

    ifu_state_t  state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_err_q;
    logic        pc_misaligned;

`ifdef YSYX_24080014_IFU_MISALIGN_CHK_EN
    assign pc_misaligned = (pc[1:0] != 2'b00);
`else
    assign pc_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IFU_IDLE;
            pc         <= RESET_PC;
            inst_q     <= NOP_INST;
            inst_pc_q  <= RESET_PC;
            inst_err_q <= 1'b0;
        end else begin
            case (state)
                IFU_IDLE: begin
                    state <= IFU_FETCH;
                end
                IFU_FETCH: begin
                    if (pc_misaligned) begin
                        // Fault is reported in place of a fetch; decode traps on it.
                        inst_q     <= NOP_INST;
                        inst_err_q <= 1'b1;
                        inst_pc_q  <= pc;
                        state      <= IFU_DELIVER;
                    end else if (imem_req_ready) begin
                        state <= IFU_WAIT_RSP;
                    end
                end
                IFU_WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        inst_q     <= imem_rsp_data;
                        inst_err_q <= imem_rsp_err;
                        inst_pc_q  <= pc;
                        state      <= IFU_DELIVER;
                    end
                end
                IFU_DELIVER: begin
                    if (inst_ready) begin
                        state <= IFU_WAIT_WB;
                    end
                end
                IFU_WAIT_WB: begin
                    if (wb_valid) begin
                        pc    <= wb_next_pc;
                        state <= IFU_FETCH;
                    end
                end
                default: begin
                    state <= IFU_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so no input reaches an output
    // combinationally.
    assign imem_req_valid = (state == IFU_FETCH) && !pc_misaligned;
    assign imem_req_addr  = {pc[31:2], 2'b00};
    assign inst_valid     = (state == IFU_DELIVER);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_err       = inst_err_q;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
module tb_ysyx_24080014_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        wb_valid;
    logic [31:0] wb_next_pc;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_24080014_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .wb_valid       (wb_valid),
        .wb_next_pc     (wb_next_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; sampling and driving happen 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_to_fetch();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0; inst_ready = 1'b0; wb_valid = 1'b0; wb_next_pc = 32'h0;
        step();
        step();
        n_cmp++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_err}
            !== {1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: got req_v=%b addr=%h iv=%b inst=%h pc=%h err=%b",
                     imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_err);
        end
    endtask

    task automatic test_first_fetch();
        rst = 1'b0;
        step();
        n_cmp++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC}) begin
            n_bad++;
            $display("FAIL first_req: got v=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        n_cmp++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL first_wait_rsp: got req_v=%b iv=%b want 0 0", imem_req_valid, inst_valid);
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093; imem_rsp_err = 1'b0;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'hDEAD_BEEF;
        n_cmp++;
        if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h0000_0093, RST_PC, 1'b0}) begin
            n_bad++;
            $display("FAIL first_deliver: got iv=%b inst=%h pc=%h err=%b want 1 00000093 %h 0",
                     inst_valid, inst, inst_pc, inst_err, RST_PC);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_cmp++;
        if ({inst_valid, imem_req_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL first_wait_wb: got iv=%b req_v=%b want 0 0", inst_valid, imem_req_valid);
        end
        wb_valid = 1'b1; wb_next_pc = 32'h8000_0100;
        step();
        wb_valid = 1'b0;
        n_cmp++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0100}) begin
            n_bad++;
            $display("FAIL wb_next_req: got v=%b addr=%h want 1 80000100", imem_req_valid, imem_req_addr);
        end
    endtask

    // Starts in FETCH at 0x80000100, ends in FETCH at 0x80000200.
    task automatic test_stall_err();
        logic [31:0] d;
        d = $urandom;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0100}) begin
                n_bad++;
                $display("FAIL req_hold[%0d]: got v=%b addr=%h want 1 80000100", k, imem_req_valid, imem_req_addr);
            end
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        n_cmp++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL req_accept_once: got req_v=%b iv=%b want 0 0", imem_req_valid, inst_valid);
        end
        step();
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rsp_wait: got iv=%b want 0", inst_valid);
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = d; imem_rsp_err = 1'b1;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = ~d;
        for (int k = 0; k < 3; k++) begin
            wb_valid = (k == 1); wb_next_pc = 32'h1234_5678;
            n_cmp++;
            if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, d, 32'h8000_0100, 1'b1}) begin
                n_bad++;
                $display("FAIL err_deliver_hold[%0d]: got iv=%b inst=%h pc=%h err=%b want 1 %h 80000100 1",
                         k, inst_valid, inst, inst_pc, inst_err, d);
            end
            step();
        end
        wb_valid = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL deliver_after_wb_pulse: got iv=%b want 1", inst_valid);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0; imem_rsp_err = 1'b1;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
        n_cmp++;
        if ({inst_valid, imem_req_valid, inst, inst_err} !== {1'b0, 1'b0, d, 1'b1}) begin
            n_bad++;
            $display("FAIL stray_rsp_in_wait_wb: got iv=%b req_v=%b inst=%h err=%b want 0 0 %h 1",
                     inst_valid, imem_req_valid, inst, inst_err, d);
        end
        wb_valid = 1'b1; wb_next_pc = 32'h8000_0200;
        step();
        wb_valid = 1'b0;
        n_cmp++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0200}) begin
            n_bad++;
            $display("FAIL wb_after_stall: got v=%b addr=%h want 1 80000200", imem_req_valid, imem_req_addr);
        end
    endtask

    // Reference: each instruction is fetched from the word containing pc,
    // delivered with the memory's data/err and the full pc, then the next
    // pc comes only from the write-back port.
    task automatic test_random();
        logic [31:0] pc_m, exp_inst, exp_pc, npc, d;
        logic        exp_err, e, mis;
        int          dly;
        pc_m = 32'h8000_0200;
        for (int it = 0; it < 40; it++) begin
            mis = (pc_m[1:0] != 2'b00);
`ifdef YSYX_24080014_IFU_MISALIGN_CHK_EN
            if (mis) begin
                n_cmp++;
                if ({imem_req_valid, inst_valid} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rnd_misalign_noreq[%0d]: got req_v=%b iv=%b want 0 0", it, imem_req_valid, inst_valid);
                end
                imem_req_ready = $urandom_range(0, 1);
                step();
                imem_req_ready = 1'b0;
                exp_inst = NOP; exp_err = 1'b1; exp_pc = pc_m;
            end else
`endif
            begin
                dly = $urandom_range(0, 3);
                for (int k = 0; k <= dly; k++) begin
                    imem_req_ready = (k == dly);
                    imem_rsp_valid = (k == dly) && ($urandom_range(0, 1) == 1);
                    imem_rsp_data  = 32'hFFFF_0000;
                    n_cmp++;
                    if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, pc_m[31:2], 2'b00, 1'b0}) begin
                        n_bad++;
                        $display("FAIL rnd_req[%0d]: got v=%b addr=%h iv=%b want 1 %h 0",
                                 it, imem_req_valid, imem_req_addr, inst_valid, {pc_m[31:2], 2'b00});
                    end
                    step();
                end
                imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
                dly = $urandom_range(1, 3);
                for (int k = 1; k < dly; k++) begin
                    n_cmp++;
                    if ({imem_req_valid, inst_valid} !== 2'b00) begin
                        n_bad++;
                        $display("FAIL rnd_rsp_wait[%0d]: got req_v=%b iv=%b want 0 0", it, imem_req_valid, inst_valid);
                    end
                    step();
                end
                d = $urandom; e = ($urandom_range(0, 3) == 0);
                imem_rsp_valid = 1'b1; imem_rsp_data = d; imem_rsp_err = e;
                step();
                imem_rsp_valid = 1'b0; imem_rsp_data = $urandom; imem_rsp_err = 1'b0;
                exp_inst = d; exp_err = e; exp_pc = pc_m;
            end
            dly = $urandom_range(0, 2);
            for (int k = 0; k <= dly; k++) begin
                inst_ready = (k == dly);
                wb_valid   = (k != dly) && ($urandom_range(0, 1) == 1);
                wb_next_pc = $urandom;
                n_cmp++;
                if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, exp_inst, exp_pc, exp_err}) begin
                    n_bad++;
                    $display("FAIL rnd_deliver[%0d]: got iv=%b inst=%h pc=%h err=%b want 1 %h %h %b",
                             it, inst_valid, inst, inst_pc, inst_err, exp_inst, exp_pc, exp_err);
                end
                step();
            end
            inst_ready = 1'b0; wb_valid = 1'b0;
            dly = $urandom_range(0, 2);
            for (int k = 0; k < dly; k++) begin
                imem_rsp_valid = ($urandom_range(0, 1) == 1);
                n_cmp++;
                if ({imem_req_valid, inst_valid} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rnd_wait_wb[%0d]: got req_v=%b iv=%b want 0 0", it, imem_req_valid, inst_valid);
                end
                step();
            end
            imem_rsp_valid = 1'b0;
            npc = $urandom;
            if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
            wb_valid = 1'b1; wb_next_pc = npc;
            step();
            wb_valid = 1'b0;
            pc_m = npc;
        end
    endtask

    task automatic test_misalign();
        reset_to_fetch();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
        step();
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        wb_valid = 1'b1; wb_next_pc = 32'h8000_0102;
        step();
        wb_valid = 1'b0;
`ifdef YSYX_24080014_IFU_MISALIGN_CHK_EN
        n_cmp++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL misalign_noreq: got req_v=%b iv=%b want 0 0", imem_req_valid, inst_valid);
        end
        step();
        n_cmp++;
        if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, NOP, 32'h8000_0102, 1'b1}) begin
            n_bad++;
            $display("FAIL misalign_fault: got iv=%b inst=%h pc=%h err=%b want 1 00000013 80000102 1",
                     inst_valid, inst, inst_pc, inst_err);
        end
`else
        n_cmp++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0100}) begin
            n_bad++;
            $display("FAIL misalign_silent_req: got v=%b addr=%h want 1 80000100", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0513;
        step();
        imem_rsp_valid = 1'b0;
        n_cmp++;
        if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, 32'h00A0_0513, 32'h8000_0102, 1'b0}) begin
            n_bad++;
            $display("FAIL misalign_silent_deliver: got iv=%b inst=%h pc=%h err=%b want 1 00a00513 80000102 0",
                     inst_valid, inst, inst_pc, inst_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        reset_to_fetch();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        n_cmp++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_in_wait_rsp: got req_v=%b iv=%b want 0 0", imem_req_valid, inst_valid);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_err}
            !== {1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset_values: got req_v=%b addr=%h iv=%b inst=%h pc=%h err=%b",
                     imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_err);
        end
        rst = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
        step();
        imem_rsp_valid = 1'b0;
        n_cmp++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst} !== {1'b1, RST_PC, 1'b0, NOP}) begin
            n_bad++;
            $display("FAIL mid_refetch: got req_v=%b addr=%h iv=%b inst=%h want 1 %h 0 %h",
                     imem_req_valid, imem_req_addr, inst_valid, inst, RST_PC, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_err();
        test_random();
        test_misalign();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
